store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Small in-order FIFO of pending word stores in the MEM stage, between the pipeline and the data cache.
- Accepts stores from the pipeline through a push handshake and releases them oldest-first to the cache through a drain handshake.
- Provides same-cycle load forwarding, so a load whose address matches a buffered store gets the youngest matching data.

Parameters:
- ENTRY_COUNT, 4, number of store entries; any integer >= 1, not restricted to powers of two.
- ADDR_WIDTH, 32, width of store and load addresses.
- DATA_WIDTH, 32, width of store data.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- sb_push_valid  in  1  the pipeline presents a store this cycle.
- sb_push_addr  in  ADDR_WIDTH  store address.
- sb_push_data  in  DATA_WIDTH  store data.
- sb_push_ready  out  1  the buffer can accept a push this cycle.
- sb_drain_valid  out  1  the head entry is valid.
- sb_drain_addr  out  ADDR_WIDTH  head (oldest) entry address.
- sb_drain_data  out  DATA_WIDTH  head (oldest) entry data.
- sb_drain_ready  in  1  the consumer takes the head entry this cycle.
- load_addr  in  ADDR_WIDTH  address of the load being looked up.
- bypass_data  out  DATA_WIDTH  forwarded data for load_addr.
- bypass_hit  out  1  load_addr matches at least one valid entry.

Behaviour:
- Storage:
  - Circular array of ENTRY_COUNT {valid, addr, data} entries.
  - Head pointer, tail pointer, and a count ranging 0..ENTRY_COUNT.
  - Pointers wrap from ENTRY_COUNT-1 to 0.
- Reset (clock edge with reset==0):
  - Clears all valid bits, head, tail and count; takes priority over push and drain that cycle.
  - After reset: sb_push_ready=1, sb_drain_valid=0, sb_drain_addr=0, sb_drain_data=0, bypass_hit=0, bypass_data=0.
- Push:
  - sb_push_ready = (count < ENTRY_COUNT). It depends only on registered state, not on sb_drain_ready.
  - A push happens on an edge where sb_push_valid && sb_push_ready. The entry is written at tail, tail advances, count increments.
  - A push while full is ignored: no state change, no error.
- Drain:
  - sb_drain_valid = (count > 0). sb_drain_addr and sb_drain_data show the head entry combinationally; both are 0 when empty.
  - A pop happens on an edge where sb_drain_valid && sb_drain_ready. The head entry is invalidated, head advances, count decrements.
  - sb_drain_ready while empty is ignored.
- Simultaneous push and pop in one cycle:
  - Both take effect and count is unchanged.
  - When empty, only the push happens. A pushed entry is never drained in the same cycle; it first appears at the drain port on the following cycle.
  - When full, sb_push_ready=0, so only the pop happens.
- Latency:
  - A pushed entry is visible to bypass and to the drain port from the cycle after the accepting edge.
  - An entry stays visible to bypass until the edge that pops it.
- Load bypass (purely combinational):
  - Compares load_addr against every valid entry using a full ADDR_WIDTH equality; there is no byte masking.
  - bypass_hit = 1 if any valid entry matches.
  - bypass_data = data of the youngest matching entry, meaning the one closest to tail in program order. It is 0 when there is no hit.
  - Entries are never coalesced: a repeated store to the same address occupies a new entry, and bypass returns the newest value.
- Ordering: drain order always equals push order, including across pointer wrap-around.

Test Plan:
- Reset then idle:
  - Drive reset=0 for 2 cycles.
  - Required: sb_push_ready=1, sb_drain_valid=0, bypass_hit=0, sb_drain_addr=0 and sb_drain_data=0.
- Fill to full:
  - Push (0x10,0xA),(0x14,0xB),(0x18,0xC),(0x1C,0xD) with sb_drain_ready=0.
  - Required: sb_push_ready=0 after the 4th push.
  - Then push (0x20,0xE): ignored; draining returns A,B,C,D in order and 0x20 never appears.
- Bypass youngest:
  - Push (0x40,0x1) then (0x40,0x2); set load_addr=0x40.
  - Required: bypass_hit=1, bypass_data=0x2.
  - With load_addr=0x44: bypass_hit=0, bypass_data=0.
- Simultaneous push and pop:
  - Start with 2 entries and assert sb_push_valid and sb_drain_ready together.
  - Required: count stays 2, oldest entry removed, new entry at tail, sb_push_ready stays 1.
- Wrap-around:
  - Run 10 interleaved pushes and pops with addresses 0x100+4*i and data i.
  - Required: drain sequence is 0..9 in order, and bypass for each still-resident address returns its data.
- Reset mid-operation:
  - Hold 3 entries, then assert reset=0 together with sb_push_valid=1 and sb_drain_ready=1.
  - Required next cycle: empty, bypass_hit=0 for all previously stored addresses.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : In-order FIFO of pending word stores with same-cycle load
//            forwarding of the youngest matching store.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int ENTRY_COUNT = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sb_push_valid,
    input  logic [ADDR_WIDTH-1:0] sb_push_addr,
    input  logic [DATA_WIDTH-1:0] sb_push_data,
    output logic                  sb_push_ready,
    output logic                  sb_drain_valid,
    output logic [ADDR_WIDTH-1:0] sb_drain_addr,
    output logic [DATA_WIDTH-1:0] sb_drain_data,
    input  logic                  sb_drain_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic [DATA_WIDTH-1:0] bypass_data,
    output logic                  bypass_hit
);

    localparam int                 c_ptr_w   = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam int                 c_cnt_w   = $clog2(ENTRY_COUNT + 1);
    localparam int unsigned        c_entries = ENTRY_COUNT;
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(ENTRY_COUNT);

    logic [ENTRY_COUNT-1:0] r_valid;
    logic [ADDR_WIDTH-1:0]  r_addr [ENTRY_COUNT];
    logic [DATA_WIDTH-1:0]  r_data [ENTRY_COUNT];
    logic [c_ptr_w-1:0]     r_head;
    logic [c_ptr_w-1:0]     r_tail;
    logic [c_cnt_w-1:0]     r_count;
    logic                   w_push;
    logic                   w_pop;

    // Modular add for pointers; ENTRY_COUNT need not be a power of two.
    function automatic logic [c_ptr_w-1:0] f_wrap(input logic [c_ptr_w-1:0] base,
                                                  input int unsigned        off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= c_entries) begin
            sum = sum - c_entries;
        end
        return c_ptr_w'(sum);
    endfunction

    assign sb_push_ready  = (r_count < c_full);
    assign sb_drain_valid = (r_count != '0);
    assign sb_drain_addr  = sb_drain_valid ? r_addr[r_head] : '0;
    assign sb_drain_data  = sb_drain_valid ? r_data[r_head] : '0;

    assign w_push = sb_push_valid && sb_push_ready;
    assign w_pop  = sb_drain_valid && sb_drain_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= sb_push_addr;
                r_data[r_tail]  <= sb_push_data;
                r_tail          <= f_wrap(r_tail, 1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= f_wrap(r_head, 1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        logic [c_ptr_w-1:0] w_idx;
        w_idx       = '0;
        bypass_hit  = 1'b0;
        bypass_data = '0;
        for (int k = 0; k < ENTRY_COUNT; k++) begin
            w_idx = f_wrap(r_head, k);
            if (r_valid[w_idx] && (r_addr[w_idx] == load_addr)) begin
                bypass_hit  = 1'b1;
                bypass_data = r_data[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed and randomized checks of store_buffer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sb_push_valid = 1'b0;
    logic [31:0] sb_push_addr = '0;
    logic [31:0] sb_push_data = '0;
    logic        sb_push_ready;
    logic        sb_drain_valid;
    logic [31:0] sb_drain_addr;
    logic [31:0] sb_drain_data;
    logic        sb_drain_ready = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] bypass_data;
    logic        bypass_hit;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] drained[$];
    int          n_asserts = 0;
    int          n_fail    = 0;

    always #5 clock = ~clock;

    store_buffer #(.ENTRY_COUNT(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .sb_push_valid  (sb_push_valid),
        .sb_push_addr   (sb_push_addr),
        .sb_push_data   (sb_push_data),
        .sb_push_ready  (sb_push_ready),
        .sb_drain_valid (sb_drain_valid),
        .sb_drain_addr  (sb_drain_addr),
        .sb_drain_data  (sb_drain_data),
        .sb_drain_ready (sb_drain_ready),
        .load_addr      (load_addr),
        .bypass_data    (bypass_data),
        .bypass_hit     (bypass_hit)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pa, input logic [31:0] pd,
                         input logic dr, input logic [31:0] la);
        sb_push_valid  = pv;
        sb_push_addr   = pa;
        sb_push_data   = pd;
        sb_drain_ready = dr;
        load_addr      = la;
        #2;
    endtask

    // Reference: queue front is the oldest store, youngest match searched from the back.
    task automatic check_all();
        logic        exp_hit;
        logic [31:0] exp_bd;
        exp_hit = 1'b0;
        exp_bd  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == load_addr) begin
                exp_hit = 1'b1;
                exp_bd  = q[i].d;
                break;
            end
        end
        chk("push_ready", sb_push_ready, q.size() < N);
        chk("drain_valid", sb_drain_valid, q.size() > 0);
        chk("drain_addr", sb_drain_addr, (q.size() > 0) ? q[0].a : 32'h0);
        chk("drain_data", sb_drain_data, (q.size() > 0) ? q[0].d : 32'h0);
        chk("bypass_hit", bypass_hit, exp_hit);
        chk("bypass_data", bypass_data, exp_bd);
    endtask

    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = reset && sb_push_valid && (q.size() < N);
        do_pop  = reset && sb_drain_ready && (q.size() > 0);
        if (do_pop) begin
            drained.push_back(sb_drain_data);
            void'(q.pop_front());
        end
        if (do_push) q.push_back('{a: sb_push_addr, d: sb_push_data});
        if (!reset) q.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic pv, input logic [31:0] pa, input logic [31:0] pd,
                        input logic dr, input logic [31:0] la);
        drive(pv, pa, pd, dr, la);
        check_all();
        tick();
    endtask

    initial begin
        // Reset then idle
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        drive(0, 0, 0, 0, 32'h10);
        check_all();
        chk("rst_push_ready", sb_push_ready, 1);
        chk("rst_drain_valid", sb_drain_valid, 0);
        chk("rst_bypass_hit", bypass_hit, 0);
        chk("rst_drain_addr", sb_drain_addr, 0);
        chk("rst_drain_data", sb_drain_data, 0);
        tick();

        // Fill to full, then an ignored push
        for (int i = 0; i < 4; i++) step(1, 32'h10 + 4 * i, 32'hA + i, 0, 32'h10);
        drive(1, 32'h20, 32'hE, 0, 32'h20);
        check_all();
        chk("full_push_ready", sb_push_ready, 0);
        tick();
        drive(0, 0, 0, 0, 32'h20);
        chk("full_no_20", bypass_hit, 0);
        drained.delete();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h20);
        chk("fill_drain_count", drained.size(), 4);
        for (int i = 0; i < drained.size(); i++) chk("fill_drain_order", drained[i], 32'hA + i);

        // Bypass youngest
        step(1, 32'h40, 32'h1, 0, 32'h40);
        step(1, 32'h40, 32'h2, 0, 32'h40);
        drive(0, 0, 0, 0, 32'h40);
        check_all();
        chk("byp_hit_40", bypass_hit, 1);
        chk("byp_data_40", bypass_data, 32'h2);
        drive(0, 0, 0, 0, 32'h44);
        check_all();
        chk("byp_hit_44", bypass_hit, 0);
        chk("byp_data_44", bypass_data, 0);
        tick();

        // Simultaneous push and pop with two entries resident
        step(1, 32'h50, 32'h3, 1, 32'h40);
        drive(0, 0, 0, 0, 32'h50);
        check_all();
        chk("sim_head_addr", sb_drain_addr, 32'h40);
        chk("sim_head_data", sb_drain_data, 32'h2);
        chk("sim_push_ready", sb_push_ready, 1);
        chk("sim_tail_data", bypass_data, 32'h3);
        tick();
        step(1, 32'h60, 32'h4, 0, 32'h50);
        step(1, 32'h64, 32'h5, 0, 32'h50);
        drive(0, 0, 0, 0, 32'h60);
        chk("sim_count_full", sb_push_ready, 0);
        for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 0, 0, 1, 32'h60);

        // Wrap-around with interleaved pushes and pops
        drained.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h100 + 4 * i, i, i >= 2, (i > 0) ? 32'h100 + 4 * (i - 1) : 32'h100);
            check_all();
            if (i > 0) chk("wrap_bypass", bypass_data, i - 1);
            tick();
        end
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 32'h100 + 4 * 9);
        chk("wrap_count", drained.size(), 10);
        for (int i = 0; i < drained.size(); i++) chk("wrap_order", drained[i], i);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 4 * i, 32'h70 + i, 0, 32'h300);
        reset = 1'b0;
        step(1, 32'h30C, 32'h77, 1, 32'h300);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 32'h300 + 4 * i);
            check_all();
            chk("mid_rst_hit", bypass_hit, 0);
        end
        chk("mid_rst_empty", sb_drain_valid, 0);
        tick();

        // Randomized traffic over a small address pool
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            step(1'($urandom_range(0, 1)), 32'h200 + 4 * $urandom_range(0, 5), $urandom,
                 1'($urandom_range(0, 2) == 0), 32'h200 + 4 * $urandom_range(0, 6));
        end
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
